// File: rtl/ahb_mst_arbiter.sv
// rtl/ahb_mst_arbiter.sv - two-master AHB-lite arbiter (LSU/IFU onto one slave port)
//
// Purpose: grants the slave address bus to m0 (LSU) or m1 (IFU), muxes the
// address phase combinationally from the owner, and steers write data and
// error responses to whichever master owns the current data phase.
// Configuration: define AHB_ARB_RR_EN for a round-robin tie-break through a
// last-winner register; undefined gives fixed priority with m0 winning.
//
// Ports:
//   clk, rst_n                clock (rising edge), asynchronous active-low reset
//   mN_htrans_i .. mN_hwdata_i  master N request: transfer type, address,
//                             write flag, {hsize,hburst,hprot}, lock, write data
//   mN_hrdata_o/hready_o/hresp_o  read data, ready and error response to master N
//   s_htrans_o .. s_hwdata_o  muxed address phase and write data to the slave
//   s_hrdata_i/hready_i/hresp_i   slave read data, ready and response
//   gnt_o                     one-hot address-bus owner, 00 = none
module ahb_mst_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    m0_htrans_i,
    input  logic [AW-1:0] m0_haddr_i,
    input  logic          m0_hwrite_i,
    input  logic [9:0]    m0_hctrl_i,
    input  logic          m0_hmastlock_i,
    input  logic [DW-1:0] m0_hwdata_i,
    output logic [DW-1:0] m0_hrdata_o,
    output logic          m0_hready_o,
    output logic          m0_hresp_o,
    input  logic [1:0]    m1_htrans_i,
    input  logic [AW-1:0] m1_haddr_i,
    input  logic          m1_hwrite_i,
    input  logic [9:0]    m1_hctrl_i,
    input  logic          m1_hmastlock_i,
    input  logic [DW-1:0] m1_hwdata_i,
    output logic [DW-1:0] m1_hrdata_o,
    output logic          m1_hready_o,
    output logic          m1_hresp_o,
    output logic [1:0]    s_htrans_o,
    output logic [AW-1:0] s_haddr_o,
    output logic          s_hwrite_o,
    output logic [9:0]    s_hctrl_o,
    output logic          s_hmastlock_o,
    output logic [DW-1:0] s_hwdata_o,
    input  logic [DW-1:0] s_hrdata_i,
    input  logic          s_hready_i,
    input  logic          s_hresp_i,
    output logic [1:0]    gnt_o
);

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t     state_q, state_d, win_state;
    logic [1:0] data_own_q, data_own_d;   // one-hot owner of the data phase
    logic       req0, req1, arb_pt;
`ifdef AHB_ARB_RR_EN
    logic       last_q, last_d;           // 1 = m1 won the last tie
`endif

    assign req0  = m0_htrans_i[1];
    assign req1  = m1_htrans_i[1];
    assign gnt_o = state_q;

    // Address phase mux: owner passes straight through, IDLE drives zeros.
    always_comb begin
        s_htrans_o    = 2'b00;
        s_haddr_o     = '0;
        s_hwrite_o    = 1'b0;
        s_hctrl_o     = '0;
        s_hmastlock_o = 1'b0;
        case (state_q)
            OWN0: begin
                s_htrans_o    = m0_htrans_i;
                s_haddr_o     = m0_haddr_i;
                s_hwrite_o    = m0_hwrite_i;
                s_hctrl_o     = m0_hctrl_i;
                s_hmastlock_o = m0_hmastlock_i;
            end
            OWN1: begin
                s_htrans_o    = m1_htrans_i;
                s_haddr_o     = m1_haddr_i;
                s_hwrite_o    = m1_hwrite_i;
                s_hctrl_o     = m1_hctrl_i;
                s_hmastlock_o = m1_hmastlock_i;
            end
            default: ;
        endcase
    end

    // The owner releases only by presenting IDLE unlocked while the slave is
    // ready; that same edge retires its last data phase, so the next owner's
    // address phase never overlaps a foreign data phase.
    assign arb_pt = s_hready_i &&
                    ((state_q == IDLE) || (!s_htrans_o[1] && !s_hmastlock_o));

    always_comb begin
        win_state = IDLE;
        if (req0 && req1) begin
`ifdef AHB_ARB_RR_EN
            win_state = last_q ? OWN0 : OWN1;
`else
            win_state = OWN0;
`endif
        end else if (req0) begin
            win_state = OWN0;
        end else if (req1) begin
            win_state = OWN1;
        end
    end

`ifdef AHB_ARB_RR_EN
    // Only contested grants move the last-winner pointer.
    always_comb begin
        last_d = last_q;
        if (arb_pt && req0 && req1) begin
            last_d = (win_state == OWN1);
        end
    end
`endif

    always_comb begin
        state_d    = arb_pt ? win_state : state_q;
        data_own_d = data_own_q;
        if (s_hready_i) begin
            data_own_d = s_htrans_o[1] ? state_q : 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_own_q <= 2'b00;
`ifdef AHB_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            data_own_q <= data_own_d;
`ifdef AHB_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    // A waiting requester is stalled; a non-requesting non-owner sees ready.
    assign m0_hready_o = (state_q == OWN0) ? s_hready_i : !req0;
    assign m1_hready_o = (state_q == OWN1) ? s_hready_i : !req1;

    assign m0_hrdata_o = s_hrdata_i;
    assign m1_hrdata_o = s_hrdata_i;

    assign m0_hresp_o  = data_own_q[0] & s_hresp_i;
    assign m1_hresp_o  = data_own_q[1] & s_hresp_i;

    always_comb begin
        case (data_own_q)
            2'b01:   s_hwdata_o = m0_hwdata_i;
            2'b10:   s_hwdata_o = m1_hwdata_i;
            default: s_hwdata_o = '0;
        endcase
    end

endmodule
